bf_assembler: RTL and testbench
===============================

Name: bf_assembler

Overview:
- Hardware front end for the brainfuck core: accepts raw brainfuck source one byte per cycle and emits the packed 16-bit instruction image the core executes.
- Instruction word is {opcode[2:0], argument[12:0]}.
- Run-length merges + - > <, resolves bracket targets with a LIFO, and appends the 0x0000 halt word.
- Sits between a host/UART byte stream and the instruction memory write port.

Parameters:
STACK_DEPTH, 64, maximum bracket nesting depth.
MAX_RUN, 8191, largest argument emitted for a merged run; range 1..8191.

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous pulse; returns to RUN with empty state, wr_addr 0.
in_valid  input  1  source byte valid.
in_ready  output  1  block can accept a byte this cycle.
in_char  input  8  ASCII source byte.
in_last  input  1  qualifies the final byte; that byte is still processed.
wr_en  output  1  instruction memory write strobe.
wr_addr  output  13  write address.
wr_data  output  16  instruction word.
done  output  1  image complete, halt word written; held until clear or reset.
error  output  1  compilation failed; held until clear or reset.
err_code  output  2  0 none, 1 unmatched ']', 2 unmatched '[', 3 program or stack overflow.
prog_len  output  13  instructions written, excluding halt word.

Behaviour:
- Reset: state RUN, pending empty, stack empty, next address 0; all outputs 0 (in_ready 0 while reset_n low, 1 from first cycle after release).
- Opcodes: + 0, - 1, > 2, < 3, . 4, , 5, [ 6, ] 7.
- . and , carry argument 0.
- [ argument = address of matching ]; ] argument = address of matching [.
- Any other byte is a comment: consumed, emits nothing, and does not break a run.
- Pending register holds {op, count}. Accepted command byte:
  - Same mergeable op as pending and count<MAX_RUN: count+1, no write.
  - Otherwise: flush pending (if valid) to next address, then load the new op with count 1.
  - . , [ ] never merge.
- At most one write per cycle. Argument is count, never 0, so no non-halt word equals 0x0000.
- Flushing [ at address A: write {6,0}, push A. Stack full: error code 3.
- Flushing ] at address A: pop B, write {7,B}.
  - Next cycle, state PATCH (in_ready=0): write {6,A} to B.
  - Stack empty at flush: no write, error code 1.
- Overflow: any non-halt write to address 8191 is suppressed and raises error code 3; address 8191 is reserved for the halt word.
- End sequence, after the in_last byte is accepted (after PATCH if one is pending):
  - FLUSH_END: flush pending if valid; PATCH follows if it was ].
  - TERM: stack non-empty gives error code 2; otherwise write 0x0000 at next address, set prog_len, go to DONE.
- DONE and ERR: in_ready=0, no writes, flags held.
- Errors are detected in the cycle of the offending write attempt; error and err_code are registered and appear the next cycle.
- prog_len is also valid in ERR (instructions written so far).
- clear takes priority over all events. Reset mid-operation abandons the image; memory contents are not guaranteed.

Optional Feature:
- BFCORE_CANCEL_EN defined: an incoming op opposite to pending (+/-, >/<) decrements count instead of flushing; count reaching 0 empties pending.
- Undefined: opposite ops are flushed as separate instructions.

Decomposition:
- Shared package bf_pkg holds:
  - opcode constants OP_INC..OP_LOOP_END;
  - field widths (OPCODE_W=3, ARG_W=13, INSTR_W=16);
  - HALT_WORD 0x0000;
  - err_code constants;
  - FSM state typedef {RUN, PATCH, FLUSH_END, TERM, DONE, ERR}.
- One sub-module bf_bracket_stack: 13-bit LIFO with push, pop, top, empty, full, and synchronous flush driven by clear.

Test Plan:
- "+++>>.<" with last on final byte -> writes 0:0x0003, 1:0x4002, 2:0x8000, 3:0x6001, 4:0x0000; done=1, prog_len=4.
- "[-]" -> 0:0xC000, 1:0x2001, 2:0xE000, then patch 0:0xC002, then 3:0x0000; done, prog_len=3.
- "a+ b+\n" -> single 0:0x0002 then 1:0x0000; in_ready high every RUN cycle, with random in_valid gaps.
- 8192 '+' bytes -> 0:0x1FFF, 1:0x0001, 2:0x0000.
- Error paths:
  - "]" -> no instruction write, error=1, err_code=1.
  - "[" -> 0:0xC000 then err_code=2, no halt write.
  - Nesting 65 '[' -> err_code=3.
- "++-" -> with BFCORE_CANCEL_EN: 0:0x0001, 1:0x0000; without: 0:0x0002, 1:0x2001, 2:0x0000.
- "+-" with BFCORE_CANCEL_EN -> only 0:0x0000, prog_len=0.
- clear asserted mid-stream -> next byte written at address 0.

Source files
------------

// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck assembler front end.
// Holds the opcode encodings, the instruction field widths, the halt word, the
// error codes, the assembler FSM states, the bus payload structs and the source
// byte decoder.
package bf_pkg;

   localparam int unsigned OPCODE_W = 3;
   localparam int unsigned ARG_W    = 13;
   localparam int unsigned INSTR_W  = 16;

   localparam logic [OPCODE_W-1:0] OP_INC      = 3'd0;
   localparam logic [OPCODE_W-1:0] OP_DEC      = 3'd1;
   localparam logic [OPCODE_W-1:0] OP_RIGHT    = 3'd2;
   localparam logic [OPCODE_W-1:0] OP_LEFT     = 3'd3;
   localparam logic [OPCODE_W-1:0] OP_OUT      = 3'd4;
   localparam logic [OPCODE_W-1:0] OP_IN       = 3'd5;
   localparam logic [OPCODE_W-1:0] OP_LOOP_BEG = 3'd6;
   localparam logic [OPCODE_W-1:0] OP_LOOP_END = 3'd7;

   localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0000;

   // The top address is kept free so the halt word always fits.
   localparam logic [ARG_W-1:0] ADDR_HALT_ONLY = 13'h1FFF;

   localparam logic [1:0] ERR_NONE            = 2'd0;
   localparam logic [1:0] ERR_UNMATCHED_CLOSE = 2'd1;
   localparam logic [1:0] ERR_UNMATCHED_OPEN  = 2'd2;
   localparam logic [1:0] ERR_OVERFLOW        = 2'd3;

   typedef enum logic [2:0] {
      RUN, PATCH, FLUSH_END, TERM, DONE, ERR
   } state_t;

   typedef struct packed {
      logic [OPCODE_W-1:0] op;
      logic [ARG_W-1:0]    arg;
   } instr_t;

   typedef struct packed {
      logic                valid;
      logic [OPCODE_W-1:0] op;
      logic [ARG_W-1:0]    count;
   } pend_t;

   typedef struct packed {
      logic                is_cmd;
      logic [OPCODE_W-1:0] op;
   } cmd_t;

   // Map an ASCII source byte to a command; anything else is a comment.
   function automatic cmd_t decode_char(input logic [7:0] c);
      cmd_t r;
      r.is_cmd = 1'b1;
      r.op     = OP_INC;
      case (c)
         8'h2B:   r.op = OP_INC;
         8'h2D:   r.op = OP_DEC;
         8'h3E:   r.op = OP_RIGHT;
         8'h3C:   r.op = OP_LEFT;
         8'h2E:   r.op = OP_OUT;
         8'h2C:   r.op = OP_IN;
         8'h5B:   r.op = OP_LOOP_BEG;
         8'h5D:   r.op = OP_LOOP_END;
         default: r.is_cmd = 1'b0;
      endcase
      return r;
   endfunction

   // Only the four pointer/cell arithmetic ops are run-length merged.
   function automatic logic is_mergeable(input logic [OPCODE_W-1:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/bf_bracket_stack.sv
// LIFO of open-bracket addresses used to resolve loop targets.
// Ports: clock, reset_n (async active-low), flush (synchronous empty),
//        push/push_data, pop, top_c (entry on top), empty_c, full_c.
// Push and pop are expected to be guarded by the caller against full/empty.
module bf_bracket_stack #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned W     = 13
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_c,
   output logic         empty_c,
   output logic         full_c
);

   localparam int unsigned SP_W  = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [SP_W-1:0] sp_q;
   logic [W-1:0]    mem [DEPTH];

   // Stack pointer: number of valid entries.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)   sp_q <= '0;
      else if (flush) sp_q <= '0;
      else if (push)  sp_q <= sp_q + SP_W'(1);
      else if (pop)   sp_q <= sp_q - SP_W'(1);
   end

   // Storage needs no reset; the pointer alone defines validity.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[IDX_W'(sp_q)] <= push_data;
   end

   assign top_c   = mem[IDX_W'(sp_q - SP_W'(1))];
   assign empty_c = (sp_q == '0);
   assign full_c  = (sp_q == SP_W'(DEPTH));

endmodule

// File: rtl/bf_assembler.sv
// Brainfuck source-to-instruction assembler.
// Consumes one source byte per cycle and writes 16-bit {opcode, argument}
// words to instruction memory: run-length merges + - > <, back-patches loop
// targets through a bracket stack and terminates the image with a halt word.
// Ports: clock, reset_n, clear; in_valid/in_ready/in_char/in_last byte stream;
//        wr_en/wr_addr/wr_data memory write port; done, error, err_code,
//        prog_len status.
// Build option: define BFCORE_CANCEL_EN to let opposite ops (+/-, >/<) cancel
// against the pending run instead of starting a new instruction.
module bf_assembler
   import bf_pkg::*;
#(
   parameter int unsigned STACK_DEPTH = 64,
   parameter int unsigned MAX_RUN     = 8191
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               clear,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [7:0]         in_char,
   input  logic               in_last,
   output logic               wr_en,
   output logic [ARG_W-1:0]   wr_addr,
   output logic [INSTR_W-1:0] wr_data,
   output logic               done,
   output logic               error,
   output logic [1:0]         err_code,
   output logic [ARG_W-1:0]   prog_len
);

   state_t             state_q, state_d;
   pend_t              pend_q, pend_d;
   logic [ARG_W-1:0]   addr_q, addr_d;
   logic               end_q, end_d;
   logic [ARG_W-1:0]   patch_dst_q, patch_dst_d;
   logic [ARG_W-1:0]   patch_src_q, patch_src_d;
   logic               in_ready_q, in_ready_d;
   logic               wr_en_q, wr_en_d;
   logic [ARG_W-1:0]   wr_addr_q, wr_addr_d;
   logic [INSTR_W-1:0] wr_data_q, wr_data_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [1:0]         err_code_q, err_code_d;
   logic [ARG_W-1:0]   prog_len_q, prog_len_d;

   logic               stk_push, stk_pop, stk_flush;
   logic [ARG_W-1:0]   stk_top_c;
   logic               stk_empty_c, stk_full_c;

   logic               accept_c;
   cmd_t               cmd_c;
   instr_t             fl_word_c;
   logic [1:0]         fl_err_c;
   logic               flush_req;

   bf_bracket_stack #(
      .DEPTH (STACK_DEPTH),
      .W     (ARG_W)
   ) u_stack (
      .clock     (clock),
      .reset_n   (reset_n),
      .flush     (stk_flush),
      .push      (stk_push),
      .pop       (stk_pop),
      .push_data (addr_q),
      .top_c     (stk_top_c),
      .empty_c   (stk_empty_c),
      .full_c    (stk_full_c)
   );

   assign accept_c = in_valid && in_ready_q && (state_q == RUN) && !clear;
   assign cmd_c    = decode_char(in_char);

   // Word and error outcome of flushing the pending instruction this cycle.
   always_comb begin
      fl_word_c.op  = pend_q.op;
      fl_word_c.arg = pend_q.count;
      case (pend_q.op)
         OP_OUT, OP_IN, OP_LOOP_BEG: fl_word_c.arg = '0;
         OP_LOOP_END:                fl_word_c.arg = stk_top_c;
         default:                    ;
      endcase
      fl_err_c = ERR_NONE;
      if (pend_q.op == OP_LOOP_BEG && stk_full_c)       fl_err_c = ERR_OVERFLOW;
      else if (pend_q.op == OP_LOOP_END && stk_empty_c) fl_err_c = ERR_UNMATCHED_CLOSE;
      else if (addr_q == ADDR_HALT_ONLY)                fl_err_c = ERR_OVERFLOW;
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      pend_d      = pend_q;
      addr_d      = addr_q;
      end_d       = end_q;
      patch_dst_d = patch_dst_q;
      patch_src_d = patch_src_q;
      wr_en_d     = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      done_d      = done_q;
      error_d     = error_q;
      err_code_d  = err_code_q;
      prog_len_d  = prog_len_q;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
      stk_flush   = 1'b0;
      flush_req   = 1'b0;

      case (state_q)
         RUN: begin
            if (accept_c) begin
               if (in_last) begin
                  end_d   = 1'b1;
                  state_d = FLUSH_END;
               end
               if (cmd_c.is_cmd) begin
                  if (pend_q.valid && is_mergeable(cmd_c.op) && pend_q.op == cmd_c.op &&
                      pend_q.count < ARG_W'(MAX_RUN)) begin
                     pend_d.count = pend_q.count + ARG_W'(1);
`ifdef BFCORE_CANCEL_EN
                  end else if (pend_q.valid && is_mergeable(cmd_c.op) &&
                               pend_q.op == (cmd_c.op ^ OPCODE_W'(1))) begin
                     // Opposite op undoes one step of the pending run.
                     pend_d.count = pend_q.count - ARG_W'(1);
                     if (pend_q.count == ARG_W'(1)) pend_d.valid = 1'b0;
`endif
                  end else begin
                     flush_req    = pend_q.valid;
                     pend_d.valid = 1'b1;
                     pend_d.op    = cmd_c.op;
                     pend_d.count = ARG_W'(1);
                  end
               end
            end
         end
         PATCH: begin
            // Point the matching '[' one past... at the ']' just written.
            wr_en_d        = 1'b1;
            wr_addr_d      = patch_dst_q;
            wr_data_d      = {OP_LOOP_BEG, patch_src_q};
            if (!end_q)            state_d = RUN;
            else if (pend_q.valid) state_d = FLUSH_END;
            else                   state_d = TERM;
         end
         FLUSH_END: begin
            flush_req    = pend_q.valid;
            pend_d.valid = 1'b0;
            state_d      = TERM;
         end
         TERM: begin
            prog_len_d = addr_q;
            if (!stk_empty_c) begin
               state_d    = ERR;
               error_d    = 1'b1;
               err_code_d = ERR_UNMATCHED_OPEN;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = HALT_WORD;
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         default: ;
      endcase

      // Shared flush of the pending instruction to the next address.
      if (flush_req) begin
         if (fl_err_c != ERR_NONE) begin
            state_d    = ERR;
            error_d    = 1'b1;
            err_code_d = fl_err_c;
            prog_len_d = addr_q;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = fl_word_c;
            addr_d    = addr_q + ARG_W'(1);
            if (pend_q.op == OP_LOOP_BEG) stk_push = 1'b1;
            if (pend_q.op == OP_LOOP_END) begin
               stk_pop     = 1'b1;
               patch_dst_d = stk_top_c;
               patch_src_d = addr_q;
               state_d     = PATCH;
            end
         end
      end

      if (clear) begin
         state_d     = RUN;
         pend_d      = '0;
         addr_d      = '0;
         end_d       = 1'b0;
         wr_en_d     = 1'b0;
         wr_addr_d   = '0;
         wr_data_d   = '0;
         done_d      = 1'b0;
         error_d     = 1'b0;
         err_code_d  = ERR_NONE;
         prog_len_d  = '0;
         stk_push    = 1'b0;
         stk_pop     = 1'b0;
         stk_flush   = 1'b1;
      end

      in_ready_d = (state_d == RUN);
   end

   // State and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= RUN;
         pend_q      <= '0;
         addr_q      <= '0;
         end_q       <= 1'b0;
         patch_dst_q <= '0;
         patch_src_q <= '0;
         in_ready_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
         prog_len_q  <= '0;
      end else begin
         state_q     <= state_d;
         pend_q      <= pend_d;
         addr_q      <= addr_d;
         end_q       <= end_d;
         patch_dst_q <= patch_dst_d;
         patch_src_q <= patch_src_d;
         in_ready_q  <= in_ready_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         prog_len_q  <= prog_len_d;
      end
   end

   assign in_ready = in_ready_q;
   assign wr_en    = wr_en_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign done     = done_q;
   assign error    = error_q;
   assign err_code = err_code_q;
   assign prog_len = prog_len_q;

endmodule

// File: tb/tb_bf_assembler.sv
// Directed bench for bf_assembler: expected memory writes are queued as each
// program is sent and checked in order as the write port produces them.
module tb_bf_assembler;

   logic        clock;
   logic        reset_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_char;
   logic        in_last;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [15:0] wr_data;
   logic        done;
   logic        error;
   logic [1:0]  err_code;
   logic [12:0] prog_len;

   typedef struct packed {
      logic [12:0] addr;
      logic [15:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total;
   int   bad;
   int   stalls;

   bf_assembler dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (clear),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_char  (in_char),
      .in_last  (in_last),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .done     (done),
      .error    (error),
      .err_code (err_code),
      .prog_len (prog_len)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [12:0] a, input logic [15:0] d);
      exp_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // One clock; any write seen is matched against the scoreboard head.
   task automatic tick();
      exp_t e;
      @(negedge clock);
      if (wr_en === 1'b1) begin
         total++;
         assert (exp_q.size() != 0)
         else begin
            bad++;
            $error("FAIL unexpected_write observed=%0d:%04h expected=none", wr_addr, wr_data);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            assert ({wr_addr, wr_data} === {e.addr, e.data})
            else begin
               bad++;
               $error("FAIL write observed=%0d:%04h expected=%0d:%04h",
                      wr_addr, wr_data, e.addr, e.data);
            end
         end
      end
   endtask

   task automatic send_byte(input logic [7:0] c, input logic last);
      int w;
      w = 0;
      in_valid = 1'b1;
      in_char  = c;
      in_last  = last;
      while (in_ready !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      stalls += w;
      check("accept_timeout", 32'(w < 200), 32'd1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send(input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
         end
         send_byte(s[i], 1'(i == s.len() - 1));
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Wait for completion, then check status flags and drain the scoreboard.
   task automatic finish_prog(input string name, input logic exp_done,
                              input logic [1:0] exp_code, input logic [12:0] exp_len);
      int w;
      w = 0;
      while (done !== 1'b1 && error !== 1'b1 && w < 100) begin
         tick();
         w++;
      end
      check({name, ".end_reached"}, 32'(w < 100), 32'd1);
      repeat (3) tick();
      check({name, ".done"}, 32'(done), 32'(exp_done));
      check({name, ".error"}, 32'(error), 32'(!exp_done));
      check({name, ".err_code"}, 32'(err_code), 32'(exp_code));
      check({name, ".prog_len"}, 32'(prog_len), 32'(exp_len));
      check({name, ".in_ready"}, 32'(in_ready), 32'd0);
      check({name, ".missing_writes"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      pulse_clear();
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      stalls   = 0;
      reset_n  = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_char  = 8'h00;
      in_last  = 1'b0;

      repeat (3) tick();
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.wr_en", 32'(wr_en), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.error", 32'(error), 32'd0);
      check("rst.err_code", 32'(err_code), 32'd0);
      check("rst.prog_len", 32'(prog_len), 32'd0);
      reset_n = 1'b1;
      tick();
      check("rst.in_ready_after", 32'(in_ready), 32'd1);

      // Basic merge and non-merging ops.
      push_exp(13'd0, 16'h0003);
      push_exp(13'd1, 16'h4002);
      push_exp(13'd2, 16'h8000);
      push_exp(13'd3, 16'h6001);
      push_exp(13'd4, 16'h0000);
      send("+++>>.<", 1'b0);
      finish_prog("basic", 1'b1, 2'd0, 13'd4);
      check("clear.done", 32'(done), 32'd0);
      check("clear.prog_len", 32'(prog_len), 32'd0);
      tick();
      check("clear.in_ready", 32'(in_ready), 32'd1);

      // Simple loop with back-patch.
      push_exp(13'd0, 16'hC000);
      push_exp(13'd1, 16'h2001);
      push_exp(13'd2, 16'hE000);
      push_exp(13'd0, 16'hC002);
      push_exp(13'd3, 16'h0000);
      send("[-]", 1'b0);
      finish_prog("loop", 1'b1, 2'd0, 13'd3);

      // Nested loops, final patch after the end-of-stream flush.
      push_exp(13'd0, 16'hC000);
      push_exp(13'd1, 16'hC000);
      push_exp(13'd2, 16'hE001);
      push_exp(13'd1, 16'hC002);
      push_exp(13'd3, 16'hE000);
      push_exp(13'd0, 16'hC003);
      push_exp(13'd4, 16'h0000);
      send("[[]]", 1'b0);
      finish_prog("nested", 1'b1, 2'd0, 13'd4);

      // Comments do not break a run; no back-pressure with gapped input.
      stalls = 0;
      push_exp(13'd0, 16'h0002);
      push_exp(13'd1, 16'h0000);
      send("a+ b+\n", 1'b1);
      check("comment.stalls", 32'(stalls), 32'd0);
      finish_prog("comment", 1'b1, 2'd0, 13'd1);

      // Unmatched close: nothing written.
      send("]", 1'b0);
      finish_prog("unmatched_close", 1'b0, 2'd1, 13'd0);

      // Unmatched open: bracket written, no halt.
      push_exp(13'd0, 16'hC000);
      send("[", 1'b0);
      finish_prog("unmatched_open", 1'b0, 2'd2, 13'd1);

      // 65 nested opens overflow the 64-entry stack.
      for (int i = 0; i < 64; i++) push_exp(13'(i), 16'hC000);
      for (int i = 0; i < 65; i++) send_byte(8'h5B, 1'(i == 64));
      finish_prog("stack_ovf", 1'b0, 2'd3, 13'd64);

      // Opposite ops.
`ifdef BFCORE_CANCEL_EN
      push_exp(13'd0, 16'h0001);
      push_exp(13'd1, 16'h0000);
      send("++-", 1'b0);
      finish_prog("cancel3", 1'b1, 2'd0, 13'd1);
      push_exp(13'd0, 16'h0000);
      send("+-", 1'b0);
      finish_prog("cancel2", 1'b1, 2'd0, 13'd0);
`else
      push_exp(13'd0, 16'h0002);
      push_exp(13'd1, 16'h2001);
      push_exp(13'd2, 16'h0000);
      send("++-", 1'b0);
      finish_prog("opposite3", 1'b1, 2'd0, 13'd2);
      push_exp(13'd0, 16'h0001);
      push_exp(13'd1, 16'h2001);
      push_exp(13'd2, 16'h0000);
      send("+-", 1'b0);
      finish_prog("opposite2", 1'b1, 2'd0, 13'd2);
`endif

      // Clear mid-stream discards the pending run and restarts at address 0.
      send_byte(8'h2B, 1'b0);
      send_byte(8'h2B, 1'b0);
      pulse_clear();
      push_exp(13'd0, 16'h4001);
      push_exp(13'd1, 16'h0000);
      send_byte(8'h3E, 1'b1);
      finish_prog("midclear", 1'b1, 2'd0, 13'd1);

      // Run saturates at the maximum argument and restarts.
      push_exp(13'd0, 16'h1FFF);
      push_exp(13'd1, 16'h0001);
      push_exp(13'd2, 16'h0000);
      for (int i = 0; i < 8192; i++) send_byte(8'h2B, 1'(i == 8191));
      finish_prog("max_run", 1'b1, 2'd0, 13'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
